// File: rtl/regbank_mp_pkg.sv
// Shared definitions for the multi-port register bank.
//   state_e      : sequencer state (INIT while the array is being rewritten, RUN after)
//   depth_of     : number of architectural registers for a given address width
//   zero_idx_of  : index of the hardwired zero register (top index)
//   init_val     : value the sequencer writes into entry j
package regbank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned zero_idx_of(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  // Mode 1 seeds entry j with its own index so a freshly initialised bank is
  // recognisable on a read; mode 0 clears everything.
  function automatic int unsigned init_val(input int unsigned j, input bit init_mode);
    return init_mode ? j : 32'd0;
  endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Bus between the datapath and the register bank.
//   Ready   : bank -> datapath, 1 once the post-reset initialisation has finished
//   RdAddr  : NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RdData  : NUM_RD packed read results,  port k at [k*DATA_W +: DATA_W]
//   WrEn0/WrAddr0/WrData0 : ALU writeback port (lower priority)
//   WrEn1/WrAddr1/WrData1 : load writeback port (higher priority)
// master = datapath side, slave = register bank side.
interface regbank_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       Ready;
  logic [NUM_RD*ADDR_W-1:0]   RdAddr;
  logic [NUM_RD*DATA_W-1:0]   RdData;
  logic                       WrEn0;
  logic [ADDR_W-1:0]          WrAddr0;
  logic [DATA_W-1:0]          WrData0;
  logic                       WrEn1;
  logic [ADDR_W-1:0]          WrAddr1;
  logic [DATA_W-1:0]          WrData1;

  modport master (
    input  Ready, RdData,
    output RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1
  );

  modport slave (
    output Ready, RdData,
    input  RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1
  );
endinterface

// File: rtl/regbank_mp_init_seq.sv
// Post-reset initialisation sequencer for regbank_mp.
// Walks entries 0..DEPTH-2 (the zero register is not stored), issuing one
// write per cycle, then parks in RUN with ready_o held high until reset.
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   init_we_o   : 1 while the sequencer owns the array write port
//   init_addr_o : entry being initialised
//   init_data_o : value written to that entry
//   ready_o     : registered, 1 once every entry has been written
module regbank_init_seq
  import regbank_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [DATA_W-1:0] init_data_o,
  output logic              ready_o
);

  localparam int unsigned     DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 2);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  // NOTE: state lives in clocked blocks updated only with <=, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      // The edge that writes the last stored entry also hands over to RUN.
      if (cnt_q == LAST_IDX) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign init_we_o   = (state_q == INIT);
  assign init_addr_o = cnt_q;
  assign init_data_o = DATA_W'(init_val(32'(cnt_q), INIT_MODE != 0));
  assign ready_o     = ready_q;

endmodule

// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank.
// Two write ports (port 1 beats port 0 on an address clash), NUM_RD
// combinational read ports, optional same-cycle write-to-read bypass and a
// hardwired zero register at the top index. After reset an internal sequencer
// rewrites every stored entry; until it finishes, writes are ignored and all
// read ports return zero.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : regbank_mp_if slave modport (Ready, read and write ports)
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  regbank_mp_if.slave  bus
);

  localparam int unsigned       DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(zero_idx_of(ADDR_W));

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              ready;

  regbank_init_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data),
    .ready_o     (ready)
  );

  // A write port is live only in RUN and never targets the zero register.
  logic we0_ok;
  logic we1_ok;
  assign we0_ok = bus.WrEn0 && ready && (bus.WrAddr0 != ZERO_IDX);
  assign we1_ok = bus.WrEn1 && ready && (bus.WrAddr1 != ZERO_IDX);

  // Only DEPTH-1 physical entries: the zero register has no storage.
  logic [DATA_W-1:0] mem_q [DEPTH-1];

  // NOTE: the array has no reset; the sequencer overwrites every entry after
  // reset, which keeps the storage free of reset fan-out.
  always_ff @(posedge Clk) begin
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end else begin
      if (we0_ok) mem_q[bus.WrAddr0] <= bus.WrData0;
      // Issued after port 0 so port 1 wins when both target the same entry.
      if (we1_ok) mem_q[bus.WrAddr1] <= bus.WrData1;
    end
  end

  logic [NUM_RD*DATA_W-1:0] rd_flat;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;

    assign rd_addr = bus.RdAddr[k*ADDR_W +: ADDR_W];

    // NOTE: rd_val gets a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
      rd_val = '0;
      if (!ready || rd_addr == ZERO_IDX) begin
        rd_val = '0;
      end else if (BYPASS != 0 && we1_ok && bus.WrAddr1 == rd_addr) begin
        rd_val = bus.WrData1;
      end else if (BYPASS != 0 && we0_ok && bus.WrAddr0 == rd_addr) begin
        rd_val = bus.WrData0;
      end else begin
        rd_val = mem_q[rd_addr];
      end
    end

    assign rd_flat[k*DATA_W +: DATA_W] = rd_val;
  end

  assign bus.RdData = rd_flat;
  assign bus.Ready  = ready;

endmodule
